// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, IDLE/RUN/STOP sequencing, count tick
// generation and lap-hold timing for the two-digit BCD stopwatch datapath.
// Every output comes straight from a flop.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int TICK_DIV        = 1200000,
  parameter int LAP_HOLD_TICKS  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_clear,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       btn_start,
  output logic       cnt_clear,
  output logic       cnt_inc,
  output logic       lap_capture,
  output logic       show_lap,
  output logic [1:0] state
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DVW = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST   = DVW'(TICK_DIV - 1);
  localparam logic [7:0]     LAP_RELOAD = 8'(LAP_HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  // Button bit order: 0 clear, 1 stop, 2 lap, 3 start
  logic [3:0]     btn_raw_s;
  logic [3:0]     sync1_q;
  logic [3:0]     sync2_q;
  logic [3:0]     deb_q;
  logic [3:0]     deb_prev_q;
  logic [DBW-1:0] db_cnt_q [4];
  logic [3:0]     rise_s;

  state_t         state_q, state_d;
  logic [DVW-1:0] div_q, div_d;
  logic [7:0]     lap_q, lap_d;
  logic           clr_q, clr_d;
  logic           inc_q, inc_d;
  logic           cap_q, cap_d;
  logic           show_q, show_d;
  logic           tick_s;
  logic           clr_cmd_s, stp_cmd_s, sta_cmd_s, lap_cmd_s;

  assign btn_raw_s = {btn_start, btn_lap, btn_stop, btn_clear};

  // Two-flop synchroniser plus one-cycle history of the debounced levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      deb_prev_q <= 4'b0000;
    end else begin
      sync1_q    <= btn_raw_s;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
    end
  end

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          deb_q[i]    <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign rise_s = deb_q & ~deb_prev_q;
  assign tick_s = (state_q == ST_RUN) && (div_q == DIV_LAST);

  // Command arbitration: clear > stop > start > lap, losers are dropped
  always_comb begin
    clr_cmd_s = rise_s[0];
    stp_cmd_s = rise_s[1] & ~rise_s[0];
    sta_cmd_s = rise_s[3] & ~rise_s[1] & ~rise_s[0];
    lap_cmd_s = rise_s[2] & ~rise_s[3] & ~rise_s[1] & ~rise_s[0];
  end

  // Next-state, divider, lap timer and strobe decode
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    inc_d   = 1'b0;
    cap_d   = 1'b0;

    if (state_q == ST_RUN) begin
      div_d = tick_s ? '0 : (div_q + DVW'(1));
      inc_d = tick_s;
    end else begin
      div_d = div_q;
    end

    if (tick_s && (lap_q != 8'd0)) begin
      lap_d = lap_q - 8'd1;
    end else begin
      lap_d = lap_q;
    end

    if (clr_cmd_s) begin
      state_d = ST_IDLE;
      clr_d   = 1'b1;
      inc_d   = 1'b0;
      div_d   = '0;
      lap_d   = 8'd0;
    end else if (stp_cmd_s) begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_STOP;
          div_d   = div_q;
          inc_d   = 1'b0;
        end
        default: state_d = state_q;
      endcase
    end else if (sta_cmd_s) begin
      case (state_q)
        ST_IDLE, ST_STOP: begin
          state_d = ST_RUN;
          div_d   = '0;
        end
        default: state_d = state_q;
      endcase
    end else if (lap_cmd_s) begin
      // A lap landing on a tick keeps the capture strobe; the increment is
      // suppressed so the three strobes never overlap.
      case (state_q)
        ST_RUN, ST_STOP: begin
          cap_d = 1'b1;
          inc_d = 1'b0;
          lap_d = LAP_RELOAD;
        end
        default: cap_d = 1'b0;
      endcase
    end else begin
      state_d = state_q;
    end

    // An unused encoding falls back to IDLE
    case (state_q)
      ST_IDLE, ST_RUN, ST_STOP: show_d = (lap_d != 8'd0);
      default: begin
        state_d = ST_IDLE;
        show_d  = (lap_d != 8'd0);
      end
    endcase
  end

  // State, divider, lap timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      lap_q   <= 8'd0;
      clr_q   <= 1'b0;
      inc_q   <= 1'b0;
      cap_q   <= 1'b0;
      show_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lap_q   <= lap_d;
      clr_q   <= clr_d;
      inc_q   <= inc_d;
      cap_q   <= cap_d;
      show_q  <= show_d;
    end
  end

  assign cnt_clear   = clr_q;
  assign cnt_inc     = inc_q;
  assign lap_capture = cap_q;
  assign show_lap    = show_q;
  assign state       = state_q;

endmodule
